// File: rtl/rf_access_seq.sv
// Register-file access sequencer: decode -> read operands -> hand to ALU -> single writeback.
// Define RF_SEQ_FASTWB_EN to drop the WB state and write combinationally on the result handshake.
module rf_access_seq #(
    parameter int XLEN    = 32,
    parameter int TIMEOUT = 64
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            instr_valid,
    output logic            instr_ready,
    input  logic [31:0]     instr,
    output logic [4:0]      Rs1,
    output logic [4:0]      Rs2,
    output logic [4:0]      Rd,
    output logic            we,
    output logic [XLEN-1:0] data_in,
    input  logic [XLEN-1:0] read_data1,
    input  logic [XLEN-1:0] read_data2,
    output logic            op_valid,
    input  logic            op_ready,
    output logic [XLEN-1:0] opa,
    output logic [XLEN-1:0] opb,
    input  logic            res_valid,
    output logic            res_ready,
    input  logic [XLEN-1:0] res_data,
    output logic            err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_ISSUE,
        S_WAIT,
        S_WB
    } state_t;

    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    state_t           state, state_nxt;
    logic             wr_en;
    logic             tmo_hit;
    logic [CNT_W-1:0] tmo_cnt;
    logic             unused_instr_bits;

    assign unused_instr_bits = ^{instr[31:25], instr[14:12]};

    // Only instructions that architecturally produce an rd value may write, and never x0.
    function automatic logic decode_wr_en(input logic [31:0] w);
        logic hit;
        case (w[6:0])
            7'b0110011, 7'b0010011, 7'b0000011, 7'b0110111,
            7'b0010111, 7'b1101111, 7'b1100111: hit = 1'b1;
            default:                            hit = 1'b0;
        endcase
        return hit && (w[11:7] != 5'd0);
    endfunction

    always_comb begin
        state_nxt = state;
        tmo_hit   = 1'b0;
        case (state)
            S_IDLE:  if (instr_valid) state_nxt = S_READ;
            S_READ:  state_nxt = S_ISSUE;
            S_ISSUE: if (op_ready) state_nxt = S_WAIT;
            S_WAIT: begin
                if (res_valid) begin
`ifdef RF_SEQ_FASTWB_EN
                    state_nxt = S_IDLE;
`else
                    state_nxt = wr_en ? S_WB : S_IDLE;
`endif
                end else if ((TIMEOUT != 0) && (tmo_cnt == CNT_LAST)) begin
                    tmo_hit   = 1'b1;
                    state_nxt = S_IDLE;
                end
            end
            S_WB:    state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= S_IDLE;
            Rs1     <= '0;
            Rs2     <= '0;
            Rd      <= '0;
            wr_en   <= 1'b0;
            opa     <= '0;
            opb     <= '0;
            tmo_cnt <= '0;
            err     <= 1'b0;
        end else begin
            state <= state_nxt;
            err   <= tmo_hit;
            if (state == S_IDLE && instr_valid) begin
                Rs1   <= instr[19:15];
                Rs2   <= instr[24:20];
                Rd    <= instr[11:7];
                wr_en <= decode_wr_en(instr);
            end
            if (state == S_READ) begin
                opa <= read_data1;
                opb <= read_data2;
            end
            // Counter sits at zero outside WAIT_RES, so every entry starts a fresh window.
            tmo_cnt <= (state == S_WAIT) ? tmo_cnt + CNT_W'(1) : '0;
        end
    end

`ifdef RF_SEQ_FASTWB_EN
    assign we      = (state == S_WAIT) && res_valid && wr_en;
    assign data_in = (state == S_WAIT) ? res_data : '0;
`else
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            data_in <= '0;
        end else if (state == S_WAIT && res_valid) begin
            data_in <= res_data;
        end
    end

    assign we = (state == S_WB);
`endif

    assign instr_ready = (state == S_IDLE);
    assign op_valid    = (state == S_ISSUE);
    assign res_ready   = (state == S_WAIT);

endmodule

// File: tb/tb_rf_access_seq.sv
// Randomized self-checking bench for rf_access_seq against a transaction-level register-file model.
module tb_rf_access_seq;

    localparam int XLEN  = 32;
    localparam int TMO   = 4;
    localparam int NEVER = 1000;
`ifdef RF_SEQ_FASTWB_EN
    localparam int WB_LAT = 3;
`else
    localparam int WB_LAT = 4;
`endif

    logic            clk;
    logic            rst;
    logic            instr_valid;
    logic            instr_ready;
    logic [31:0]     instr;
    logic [4:0]      Rs1, Rs2, Rd;
    logic            we;
    logic [XLEN-1:0] data_in;
    logic [XLEN-1:0] read_data1, read_data2;
    logic            op_valid;
    logic            op_ready;
    logic [XLEN-1:0] opa, opb;
    logic            res_valid;
    logic            res_ready;
    logic [XLEN-1:0] res_data;
    logic            err;

    int n_checks = 0;
    int n_errors = 0;
    int lat;

    logic [XLEN-1:0] rf     [32];
    logic [XLEN-1:0] exp_rf [32];
    logic            rf_load;

    rf_access_seq #(.XLEN(XLEN), .TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst),
        .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr),
        .Rs1(Rs1), .Rs2(Rs2), .Rd(Rd), .we(we), .data_in(data_in),
        .read_data1(read_data1), .read_data2(read_data2),
        .op_valid(op_valid), .op_ready(op_ready), .opa(opa), .opb(opb),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
        .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Environment register file: x0 reads as zero, writes land on the rising edge.
    assign read_data1 = (Rs1 == 5'd0) ? '0 : rf[Rs1];
    assign read_data2 = (Rs2 == 5'd0) ? '0 : rf[Rs2];
    always @(posedge clk) begin
        if (rf_load) begin
            for (int i = 0; i < 32; i++) rf[i] <= exp_rf[i];
        end else if (we) begin
            rf[Rd] <= data_in;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no completion, required finish within time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h required %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        lat++;
    endtask

    function automatic bit model_writes(input logic [31:0] w);
        return (w[6:0] inside {7'h33, 7'h13, 7'h03, 7'h37, 7'h17, 7'h6F, 7'h67}) && (w[11:7] != 5'd0);
    endfunction

    task automatic run_instr(input logic [31:0] w, input int op_dly, input int res_dly,
                             input logic [31:0] res, input bit rst_at_wr);
        logic [4:0] rs1, rs2, rd;
        bit         exp_wr, rv, tmo;
        int         waitc;
        rs1    = w[19:15];
        rs2    = w[24:20];
        rd     = w[11:7];
        exp_wr = model_writes(w);
        rv     = 1'b0;
        tmo    = 1'b0;
        waitc  = 0;
        while (!instr_ready && waitc < 20) begin
            @(negedge clk);
            waitc++;
        end
        chk("instr_ready_idle", instr_ready, 1);
        if (!instr_ready) return;
        chk("we_idle", we, 0);
        instr       = w;
        instr_valid = 1'b1;
        op_ready    = 1'b0;
        res_valid   = 1'b0;
        lat         = 0;
        tick();
        instr_valid = 1'b0;
        instr       = $urandom;
        chk("rs1", Rs1, rs1);
        chk("rs2", Rs2, rs2);
        chk("rd", Rd, rd);
        chk("op_valid_read", op_valid, 0);
        chk("instr_ready_busy", instr_ready, 0);
        tick();
        for (int k = 0; ; k++) begin
            chk("op_valid_issue", op_valid, 1);
            chk("opa", opa, exp_rf[rs1]);
            chk("opb", opb, exp_rf[rs2]);
            chk("we_issue", we, 0);
            op_ready = (k >= op_dly);
            tick();
            if (k >= op_dly) break;
        end
        op_ready = 1'b0;
        for (int j = 0; ; j++) begin
            chk("res_ready_wait", res_ready, 1);
            chk("op_valid_wait", op_valid, 0);
            chk("err_wait", err, 0);
            rv        = (j >= res_dly);
            tmo       = !rv && (j == TMO - 1);
            res_valid = rv;
            res_data  = rv ? res : $urandom;
            #1;
`ifdef RF_SEQ_FASTWB_EN
            chk("we_fast", we, rv && exp_wr);
            if (rv && exp_wr) begin
                chk("data_fast", data_in, res);
                chk("rd_fast", Rd, rd);
                chk("latency", lat, op_dly + res_dly + WB_LAT);
                if (rst_at_wr) begin
                    rst = 1'b0;
                    #1;
                    chk("we_async_rst", we, 0);
                end
            end
`else
            chk("we_wait", we, 0);
`endif
            tick();
            if (rv || tmo) break;
        end
        res_valid = 1'b0;
        if (tmo) begin
            chk("err_pulse", err, 1);
            chk("we_tmo", we, 0);
            chk("idle_after_tmo", instr_ready, 1);
            tick();
            chk("err_one_cycle", err, 0);
            return;
        end
`ifndef RF_SEQ_FASTWB_EN
        if (exp_wr) begin
            chk("we_wb", we, 1);
            chk("rd_wb", Rd, rd);
            chk("data_wb", data_in, res);
            chk("latency", lat, op_dly + res_dly + WB_LAT);
            chk("instr_ready_wb", instr_ready, 0);
            if (rst_at_wr) begin
                rst = 1'b0;
                #1;
                chk("we_async_rst", we, 0);
            end else begin
                exp_rf[rd] = res;
                tick();
            end
        end
`else
        if (rv && exp_wr && !rst_at_wr) exp_rf[rd] = res;
`endif
        if (!rst) begin
            chk("instr_ready_in_rst", instr_ready, 1);
            @(negedge clk);
            rst = 1'b1;
            @(negedge clk);
            chk("instr_ready_after_rst", instr_ready, 1);
            chk("rd_after_rst", Rd, 0);
            chk("we_after_rst", we, 0);
            return;
        end
        chk("we_done", we, 0);
        chk("instr_ready_done", instr_ready, 1);
        chk("err_done", err, 0);
        chk("rd_hold", Rd, rd);
    endtask

    logic [6:0] opc_tab [10];
    logic [31:0] w;

    initial begin
        opc_tab = '{7'h33, 7'h13, 7'h03, 7'h37, 7'h17, 7'h6F, 7'h67, 7'h23, 7'h63, 7'h0F};
        rst         = 1'b0;
        rf_load     = 1'b1;
        instr_valid = 1'b0;
        instr       = '0;
        op_ready    = 1'b0;
        res_valid   = 1'b0;
        res_data    = '0;
        exp_rf[0]   = '0;
        for (int i = 1; i < 32; i++) exp_rf[i] = $urandom;
        exp_rf[1] = 32'd5;
        exp_rf[2] = 32'd7;
        repeat (3) @(negedge clk);
        chk("rst_instr_ready", instr_ready, 1);
        chk("rst_op_valid", op_valid, 0);
        chk("rst_res_ready", res_ready, 0);
        chk("rst_we", we, 0);
        chk("rst_err", err, 0);
        chk("rst_rd", Rd, 0);
        chk("rst_data_in", data_in, 0);
        chk("rst_opa", opa, 0);
        rf_load = 1'b0;
        rst     = 1'b1;
        @(negedge clk);

        run_instr(32'h002081B3, 0, 0, 32'd12, 1'b0);
        run_instr(32'h00208033, 0, 0, 32'd12, 1'b0);
        run_instr(32'h0020A023, 0, 1, 32'h55, 1'b0);
        run_instr(32'h003100B3, 10, 0, 32'hCAFE0001, 1'b0);
        run_instr(32'h002081B3, 0, NEVER, 32'd0, 1'b0);
        run_instr(32'h002082B3, 0, TMO - 1, 32'h1234_5678, 1'b0);
        run_instr(32'h002082B3, 0, 0, 32'h99, 1'b1);
        run_instr(32'h002081B3, 1, 2, 32'hA5A5_0003, 1'b0);

        for (int n = 0; n < 60; n++) begin
            w      = $urandom;
            w[6:0] = opc_tab[$urandom_range(0, 9)];
            if ($urandom_range(0, 5) == 0) w[11:7] = 5'd0;
            run_instr(w, $urandom_range(0, 3), $urandom_range(0, 5), $urandom,
                      $urandom_range(0, 9) == 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
